// File: rtl/mac_host_pkg.sv
// Shared types and constants for the serial MAC host initiator.
package mac_host_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 20;

    localparam int DEF_STROBE_LO = 4;
    localparam int DEF_STROBE_HI = 2;
    localparam int DEF_SYNC_LAT  = 2;
    localparam int DEF_TIMEOUT   = 4096;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_START,
        ST_WAIT_FIN,
        ST_SETTLE,
        ST_READ_LO,
        ST_READ_HI,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mac_serial_host_if.sv
// Request/response handshake bundle for the serial MAC host.
interface mac_serial_host_if;
    import mac_host_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [OP_W-1:0]  req_a;
    logic [OP_W-1:0]  req_b;
    logic             req_acc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_timeout;

    modport slave (
        input  req_valid, req_a, req_b, req_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_timeout
    );

    modport master (
        output req_valid, req_a, req_b, req_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_timeout
    );

endinterface

// File: rtl/mac_host_sync.sv
// SYNC_LAT-deep flop chain for the asynchronous chip_* inputs.
module mac_host_sync #(
    parameter int SYNC_LAT = 2,
    parameter int W        = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [SYNC_LAT];

    // Shift each input through the synchroniser chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < SYNC_LAT; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned k = 1; k < SYNC_LAT; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_q = r_stage[SYNC_LAT-1];

endmodule

// File: rtl/mac_serial_host.sv
// Host-side initiator: serialises operands to the MAC chip, pulses START,
// waits for Finish and shifts the 20-bit result back in LSB-first.
module mac_serial_host
    import mac_host_pkg::*;
#(
    parameter int STROBE_LO = DEF_STROBE_LO,
    parameter int STROBE_HI = DEF_STROBE_HI,
    parameter int SYNC_LAT  = DEF_SYNC_LAT,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset_n,
    mac_serial_host_if.slave  bus,
    output logic              chip_a_bit,
    output logic              chip_b_bit,
    output logic              chip_strobe,
    output logic              chip_start,
    output logic              chip_do_next,
    input  logic              chip_sout,
    input  logic              chip_finish,
    input  logic              chip_carry
);

    localparam int CNT_W = $clog2(TIMEOUT + STROBE_LO + STROBE_HI + SYNC_LAT + 4);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [4:0]       r_idx, w_idx_nx;
    logic [OP_W-1:0]  r_a, r_b, w_a_nx, w_b_nx;
    logic [RES_W-1:0] r_res, w_res_nx;
    logic             r_acc, w_acc_nx;
    logic             r_carry, w_carry_nx;
    logic             r_tmo, w_tmo_nx;
    logic             r_alive;
    logic             w_sout_s, w_fin_s, w_carry_s;
    logic             w_loading;

    mac_host_sync #(.SYNC_LAT(SYNC_LAT), .W(3)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     ({chip_sout, chip_finish, chip_carry}),
        .o_q     ({w_sout_s, w_fin_s, w_carry_s})
    );

    // State and datapath registers; r_alive holds req_ready low through reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_acc   <= 1'b0;
            r_carry <= 1'b0;
            r_tmo   <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_res   <= w_res_nx;
            r_acc   <= w_acc_nx;
            r_carry <= w_carry_nx;
            r_tmo   <= w_tmo_nx;
            r_alive <= 1'b1;
        end
    end

    // Next-state and datapath updates for load, start, readout and response.
    always_comb begin
        w_next     = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_res_nx   = r_res;
        w_acc_nx   = r_acc;
        w_carry_nx = r_carry;
        w_tmo_nx   = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    w_next     = ST_LOAD_LO;
                    w_a_nx     = bus.req_a;
                    w_b_nx     = bus.req_b;
                    w_acc_nx   = bus.req_acc;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_res_nx   = '0;
                    w_carry_nx = 1'b0;
                    w_tmo_nx   = 1'b0;
                end
            end
            ST_LOAD_LO: begin
                if (r_cnt == CNT_W'(STROBE_LO - 1)) begin
                    w_next   = ST_LOAD_HI;
                    w_cnt_nx = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_LOAD_HI: begin
                if (r_cnt == CNT_W'(STROBE_HI - 1)) begin
                    w_cnt_nx = '0;
                    w_idx_nx = r_idx + 1'b1;
                    w_a_nx   = {r_a[OP_W-2:0], 1'b0};
                    w_b_nx   = {r_b[OP_W-2:0], 1'b0};
                    w_next   = (r_idx == 5'(OP_W - 1)) ? ST_START : ST_LOAD_LO;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_START: begin
                w_cnt_nx = '0;
                w_next   = ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
                if (w_fin_s) begin
                    w_next   = ST_SETTLE;
                    w_cnt_nx = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next     = ST_RESP;
                    w_tmo_nx   = 1'b1;
                    w_res_nx   = '0;
                    w_carry_nx = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_W'(SYNC_LAT + 1)) begin
                    w_carry_nx = w_carry_s;
                    w_next     = ST_READ_LO;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_READ_LO: begin
                if (r_cnt == CNT_W'(STROBE_LO - 1)) begin
                    // Shifting in from the top leaves the first sample in bit 0.
                    w_res_nx = {w_sout_s, r_res[RES_W-1:1]};
                    w_cnt_nx = '0;
                    w_next   = (r_idx == 5'(RES_W - 1)) ? ST_RESP : ST_READ_HI;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_READ_HI: begin
                if (r_cnt == CNT_W'(STROBE_HI - 1)) begin
                    w_cnt_nx = '0;
                    w_idx_nx = r_idx + 1'b1;
                    w_next   = ST_READ_LO;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next   = ST_IDLE;
                    w_tmo_nx = 1'b0;
                    w_acc_nx = 1'b0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_loading       = (r_state == ST_LOAD_LO) || (r_state == ST_LOAD_HI);
    assign chip_a_bit      = w_loading & r_a[OP_W-1];
    assign chip_b_bit      = w_loading & r_b[OP_W-1];
    assign chip_strobe     = (r_state == ST_LOAD_HI) || (r_state == ST_READ_HI);
    assign chip_start      = (r_state == ST_START) || (r_state == ST_WAIT_FIN);
    assign chip_do_next    = r_acc;

    assign bus.req_ready   = r_alive && (r_state == ST_IDLE) && !w_fin_s;
    assign bus.rsp_valid   = (r_state == ST_RESP);
    assign bus.rsp_result  = r_res;
    assign bus.rsp_carry   = r_carry;
    assign bus.rsp_timeout = r_tmo;

endmodule

// File: tb/tb_mac_serial_host.sv
// Directed bench for mac_serial_host with a behavioural MAC chip pin model.
module tb_mac_serial_host;
    import mac_host_pkg::*;

    localparam int LO  = 4;
    localparam int HI  = 2;
    localparam int SL  = 2;
    localparam int TMO = 64;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mac_serial_host_if bus();

    logic chip_a_bit, chip_b_bit, chip_strobe, chip_start, chip_do_next;
    logic chip_sout, chip_finish, chip_carry;

    mac_serial_host #(.STROBE_LO(LO), .STROBE_HI(HI), .SYNC_LAT(SL), .TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .chip_a_bit   (chip_a_bit),
        .chip_b_bit   (chip_b_bit),
        .chip_strobe  (chip_strobe),
        .chip_start   (chip_start),
        .chip_do_next (chip_do_next),
        .chip_sout    (chip_sout),
        .chip_finish  (chip_finish),
        .chip_carry   (chip_carry)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Chip model configuration, written only by the stimulus process.
    logic [19:0] m_result = '0;
    logic        m_carry  = 1'b0;
    logic        m_fin_en = 1'b1;

    // Chip model state.
    logic        ps, pst;
    int          m_nload, m_nrd, m_fcnt;
    logic [19:0] m_sh;
    logic [7:0]  m_a, m_b;
    logic        m_first_a, m_first_b, m_last_a, m_last_b;

    // Behavioural chip: latches operand bits on strobe rises, raises Finish a
    // few cycles after START, then shifts the result out on each readout strobe.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ps <= 1'b0; pst <= 1'b0;
            m_nload <= 0; m_nrd <= 0; m_fcnt <= 0;
            m_sh <= '0; m_a <= '0; m_b <= '0;
            m_first_a <= 1'b0; m_first_b <= 1'b0; m_last_a <= 1'b0; m_last_b <= 1'b0;
            chip_finish <= 1'b0; chip_sout <= 1'b0; chip_carry <= 1'b0;
        end else begin
            ps  <= chip_strobe;
            pst <= chip_start;
            if (chip_strobe && !ps) begin
                if (m_nload < 8) begin
                    m_a <= {m_a[6:0], chip_a_bit};
                    m_b <= {m_b[6:0], chip_b_bit};
                    if (m_nload == 0) begin m_first_a <= chip_a_bit; m_first_b <= chip_b_bit; end
                    if (m_nload == 7) begin m_last_a  <= chip_a_bit; m_last_b  <= chip_b_bit; end
                    m_nload <= m_nload + 1;
                end else begin
                    m_nrd     <= m_nrd + 1;
                    m_sh      <= m_sh >> 1;
                    chip_sout <= m_sh[1];
                end
            end
            if (chip_start && m_nload == 8 && m_fin_en && m_fcnt <= 5) begin
                if (m_fcnt == 5) begin
                    chip_finish <= 1'b1;
                    m_sh        <= m_result;
                    chip_sout   <= m_result[0];
                    chip_carry  <= m_carry;
                end
                m_fcnt <= m_fcnt + 1;
            end
            if (pst && !chip_start) chip_finish <= 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                m_nload <= 0; m_nrd <= 0; m_fcnt <= 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic acc);
        int t = 0;
        @(negedge clock);
        while (!bus.req_ready && t < 300) begin @(negedge clock); t++; end
        if (t >= 300) check_val("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        bus.req_a = a; bus.req_b = b; bus.req_acc = acc; bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic exp_dn, output int cyc);
        int dn_err = 0;
        cyc = 0;
        @(negedge clock);
        while (!bus.rsp_valid && cyc < 2000) begin
            if (chip_do_next !== exp_dn) dn_err++;
            @(negedge clock);
            cyc++;
        end
        check_val("rsp_valid_arrives", {31'd0, bus.rsp_valid}, 32'd1);
        check_val("do_next_held", dn_err, 0);
    endtask

    task automatic take_rsp();
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        check_val("rsp_valid_drops", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("rsp_timeout_clears", {31'd0, bus.rsp_timeout}, 32'd0);
    endtask

    initial begin
        int cyc;
        int err;
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_acc = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #2;
        check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("rst_strobe", {31'd0, chip_strobe}, 32'd0);
        check_val("rst_start", {31'd0, chip_start}, 32'd0);
        check_val("rst_result", {12'd0, bus.rsp_result}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Basic transfer
        m_result = 20'h0000F; m_carry = 1'b0;
        send_req(8'h03, 8'h05, 1'b0);
        wait_rsp(1'b0, cyc);
        check_val("basic_result", {12'd0, bus.rsp_result}, 32'h0000F);
        check_val("basic_carry", {31'd0, bus.rsp_carry}, 32'd0);
        check_val("basic_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        check_val("basic_a_bits", {24'd0, m_a}, 32'h03);
        check_val("basic_b_bits", {24'd0, m_b}, 32'h05);
        check_val("basic_load_strobes", m_nload, 8);
        take_rsp();

        // Bit order and readout
        m_result = 20'hABCDE; m_carry = 1'b1;
        send_req(8'h80, 8'h01, 1'b0);
        wait_rsp(1'b0, cyc);
        check_val("order_first_a", {31'd0, m_first_a}, 32'd1);
        check_val("order_first_b", {31'd0, m_first_b}, 32'd0);
        check_val("order_last_a", {31'd0, m_last_a}, 32'd0);
        check_val("order_last_b", {31'd0, m_last_b}, 32'd1);
        check_val("read_result", {12'd0, bus.rsp_result}, 32'hABCDE);
        check_val("read_carry", {31'd0, bus.rsp_carry}, 32'd1);
        check_val("read_strobes", m_nrd, 19);
        take_rsp();

        // Timeout: 8*(LO+HI) load cycles, one START cycle, TMO waiting cycles
        m_fin_en = 1'b0;
        send_req(8'h12, 8'h34, 1'b0);
        wait_rsp(1'b0, cyc);
        check_val("tmo_latency", cyc, 8 * (LO + HI) + 1 + TMO);
        check_val("tmo_flag", {31'd0, bus.rsp_timeout}, 32'd1);
        check_val("tmo_result", {12'd0, bus.rsp_result}, 32'd0);
        check_val("tmo_start_low", {31'd0, chip_start}, 32'd0);
        check_val("tmo_read_strobes", m_nrd, 0);
        take_rsp();
        m_fin_en = 1'b1;

        // Backpressure with a second request waiting behind the response
        m_result = 20'h12345; m_carry = 1'b0;
        send_req(8'h11, 8'h22, 1'b0);
        wait_rsp(1'b0, cyc);
        bus.req_a = 8'h0F; bus.req_b = 8'hF0; bus.req_acc = 1'b1; bus.req_valid = 1'b1;
        err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 20'h12345 ||
                bus.rsp_carry !== 1'b0 || bus.rsp_timeout !== 1'b0 ||
                bus.req_ready !== 1'b0) err++;
        end
        check_val("bp_stable", err, 0);
        m_result = 20'h54321; m_carry = 1'b1;
        take_rsp();
        @(negedge clock);
        check_val("bp_req_taken_after", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        wait_rsp(1'b1, cyc);
        check_val("acc_result", {12'd0, bus.rsp_result}, 32'h54321);
        check_val("acc_carry", {31'd0, bus.rsp_carry}, 32'd1);
        check_val("acc_do_next_resp", {31'd0, chip_do_next}, 32'd1);
        check_val("acc_b_bits", {24'd0, m_b}, 32'hF0);
        take_rsp();
        check_val("acc_do_next_clear", {31'd0, chip_do_next}, 32'd0);

        // Reset during the high phase of bit 4
        m_result = 20'h00077; m_carry = 1'b0;
        send_req(8'hA5, 8'h5A, 1'b1);
        cyc = 0;
        @(negedge clock);
        while (!(m_nload == 5 && chip_strobe) && cyc < 500) begin @(negedge clock); cyc++; end
        check_val("mid_strobe_high", {31'd0, chip_strobe}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_strobe", {31'd0, chip_strobe}, 32'd0);
        check_val("mid_rst_start", {31'd0, chip_start}, 32'd0);
        check_val("mid_rst_do_next", {31'd0, chip_do_next}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.rsp_valid !== 1'b0 || chip_strobe !== 1'b0) err++;
        end
        check_val("mid_no_response", err, 0);
        send_req(8'h3C, 8'hC3, 1'b1);
        wait_rsp(1'b1, cyc);
        check_val("post_rst_result", {12'd0, bus.rsp_result}, 32'h00077);
        check_val("post_rst_a_bits", {24'd0, m_a}, 32'h3C);
        take_rsp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
